// File: rtl/spi_command_queue.sv
// Captures SPI command bytes into the game_clk domain and queues them for game_executioner.
// The valid/ready pair to the consumer is a show-ahead FIFO head that is popped on cmd_valid & cmd_ready.
module spi_command_queue #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       game_clk,
  input  logic                       reset_n,
  input  logic [7:0]                 spi_data,
  input  logic                       spi_data_valid,
  output logic                       spi_clear,
  output logic                       cmd_valid,
  output logic [1:0]                 cmd_move,
  output logic [2:0]                 cmd_piece,
  input  logic                       cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [1:0]                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // dbg_state encoding: 0 = IDLE, 1 = CAPTURE, 2 = CLEAR_WAIT
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CAPTURE    = 2'd1,
    CLEAR_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             valid_s;
  logic [5:0]       cap_q;
  logic [4:0]       mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [7:0]       drop_count_q;
  logic             load_cap, push, drop, pop, push_ok;
  logic             unused_bits;

  // Bits [7:6] of the SPI byte carry nothing for this block.
  assign unused_bits = ^spi_data[7:6];

  always_ff @(posedge game_clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], spi_data_valid};
  end
  assign valid_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      // spi_data is only trusted once the synchronized valid has settled.
      if (load_cap) cap_q <= spi_data[5:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    load_cap = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_s) begin
          load_cap = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cap_q[5]) begin
          if (push_ok) push = 1'b1;
          else         drop = 1'b1;
        end
        state_d = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        if (!valid_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi_clear = (state_q == CLEAR_WAIT);
  assign dbg_state = state_q;

  assign cmd_valid = (count_q != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO can still take the byte if the head leaves on the same edge.
  assign push_ok   = (count_q < CW'(DEPTH)) | pop;

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cap_q[4:2], cap_q[1:0]};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign cmd_move   = mem_q[rd_ptr_q][1:0];
  assign cmd_piece  = mem_q[rd_ptr_q][4:2];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_spi_command_queue.sv
// Bench for spi_command_queue: directed steps plus randomized traffic, checked every cycle
// against a queue-based model built from the command-byte rules and the capture timing.
module tb_spi_command_queue;

  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic       game_clk = 1'b0;
  logic       reset_n;
  logic [7:0] spi_data;
  logic       spi_data_valid;
  logic       spi_clear;
  logic       cmd_valid;
  logic [1:0] cmd_move;
  logic [2:0] cmd_piece;
  logic       cmd_ready;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_count;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [4:0] exp_q[$];
  bit         exp_ovf   = 1'b0;
  int         exp_drops = 0;
  bit         exp_clear = 1'b0;
  int         hi_run    = 0;
  int         low_run   = 0;

  spi_command_queue #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .game_clk(game_clk), .reset_n(reset_n), .spi_data(spi_data),
    .spi_data_valid(spi_data_valid), .spi_clear(spi_clear), .cmd_valid(cmd_valid),
    .cmd_move(cmd_move), .cmd_piece(cmd_piece), .cmd_ready(cmd_ready), .count(count),
    .overflow(overflow), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  always #5 game_clk = ~game_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One game_clk edge: advance the model with the inputs the edge samples, then compare.
  task automatic tick();
    bit was_rst;
    was_rst = !reset_n;
    if (was_rst) begin
      exp_q.delete();
      exp_ovf = 1'b0; exp_drops = 0; exp_clear = 1'b0; hi_run = 0; low_run = 0;
    end else begin
      if (exp_q.size() != 0 && cmd_ready) void'(exp_q.pop_front());
      // Clear drops once the synchronized valid has been seen low.
      if (exp_clear && low_run >= SYNC_STAGES) exp_clear = 1'b0;
      // The byte is acted on at the (SYNC_STAGES+2)-th edge of a high valid run.
      if (spi_data_valid && hi_run + 1 == SYNC_STAGES + 2) begin
        if (spi_data[5]) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({spi_data[4:2], spi_data[1:0]});
          else begin
            exp_ovf = 1'b1;
            if (exp_drops < 255) exp_drops++;
          end
        end
        exp_clear = 1'b1;
      end
      if (spi_data_valid) begin hi_run++; low_run = 0; end
      else                begin low_run++; hi_run = 0; end
    end
    @(posedge game_clk);
    #1;
    check("count", count, exp_q.size());
    check("cmd_valid", cmd_valid, (exp_q.size() != 0));
    check("spi_clear", spi_clear, exp_clear);
    check("overflow", overflow, exp_ovf);
    check("drop_count", drop_count, exp_drops);
    if (exp_q.size() != 0) begin
      check("cmd_move", cmd_move, exp_q[0][1:0]);
      check("cmd_piece", cmd_piece, exp_q[0][4:2]);
    end
    if (was_rst) begin
      check("rst_state", dbg_state, 2'd0);
      check("rst_move", cmd_move, 2'd0);
      check("rst_piece", cmd_piece, 3'd0);
    end
  endtask

  // mode 0: cmd_ready left alone; 1: ready only on the capture edge; 2: random ready.
  task automatic send(input logic [7:0] b, input int mode, input int hold);
    int n;
    spi_data = b;
    spi_data_valid = 1'b1;
    n = 0;
    while (!(exp_clear && spi_clear) && n < 30) begin
      if (mode == 1)      cmd_ready = (hi_run == SYNC_STAGES + 1);
      else if (mode == 2) cmd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("clear_rise", (n < 30), 1);
    if (mode == 1) cmd_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (mode == 2) cmd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    spi_data_valid = 1'b0;
    spi_data = 8'($urandom);
    n = 0;
    while ((exp_clear || spi_clear) && n < 30) begin
      if (mode == 2) cmd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("clear_fall", (n < 30), 1);
  endtask

  logic [4:0] drain_tbl [4];

  initial begin
    int n;
    reset_n = 1'b0; spi_data = 8'h00; spi_data_valid = 1'b0; cmd_ready = 1'b0;

    // Reset
    repeat (3) tick();
    check("reset_state", dbg_state, 2'd0);
    check("reset_count", count, 0);
    check("reset_clear", spi_clear, 0);
    reset_n = 1'b1;
    tick();

    // Single command 8'h2D: move 1, piece 3
    spi_data = 8'h2D; spi_data_valid = 1'b1;
    repeat (3) tick();
    check("sc_edge3_valid", cmd_valid, 0);
    tick();
    check("sc_valid", cmd_valid, 1);
    check("sc_move", cmd_move, 2'd1);
    check("sc_piece", cmd_piece, 3'd3);
    check("sc_clear", spi_clear, 1);
    spi_data_valid = 1'b0;
    tick(); tick();
    check("sc_clear_hold", spi_clear, 1);
    tick();
    check("sc_clear_fall", spi_clear, 0);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    check("sc_pop_count", count, 0);

    // Ignored byte
    send(8'h0E, 0, 1);
    check("ign_count", count, 0);
    check("ign_ovf", overflow, 0);

    // Overflow: six bytes into four slots
    for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), 0, $urandom_range(0, 2));
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 2);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", cmd_move, i);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    end
    check("ovf_drained", count, 0);

    // Simultaneous push and pop while full
    send(8'h21, 0, 0); send(8'h26, 0, 0); send(8'h2B, 0, 0); send(8'h2C, 0, 0);
    send(8'h3F, 1, 0);
    check("sim_count", count, 4);
    check("sim_drops", drop_count, 2);
    drain_tbl[0] = 5'b001_10; drain_tbl[1] = 5'b010_11;
    drain_tbl[2] = 5'b011_00; drain_tbl[3] = 5'b111_11;
    for (int i = 0; i < 4; i++) begin
      check("sim_order", {cmd_piece, cmd_move}, drain_tbl[i]);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    end
    check("sim_drained", count, 0);

    // Reset during CAPTURE with valid still high
    send(8'h22, 0, 0);
    spi_data = 8'h35; spi_data_valid = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    reset_n = 1'b0;
    tick();
    check("rm_count", count, 0);
    check("rm_ovf", overflow, 0);
    check("rm_drops", drop_count, 0);
    reset_n = 1'b1;
    send(8'h35, 0, 0);
    check("rm_recapture_count", count, 1);
    check("rm_move", cmd_move, 2'd1);
    check("rm_piece", cmd_piece, 3'd5);

    // Randomized traffic with random consumer stalls
    for (int k = 0; k < 25; k++) begin
      send(8'($urandom), 2, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        cmd_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    cmd_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 10) begin tick(); n++; end
    cmd_ready = 1'b0;
    check("rand_drained", count, 0);

    // drop_count saturation
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 256; i++) send(8'h3C, 0, 0);
    check("sat_drops", drop_count, 255);
    check("sat_ovf", overflow, 1);
    check("sat_count", count, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_command_queue.md
# spi_command_queue

Captures command bytes from the SPI receiver into the `game_clk` domain and buffers them in a small FIFO. It then presents them one at a time to `game_executioner` through a valid/ready handshake. It sits between `spi` and `game_executioner`. It replaces the ad-hoc synchronizer pair that generated `move_clk` and `clear`, so that rapid button presses are queued instead of lost.

## Interface
Parameters:
- `DEPTH`, 4, number of FIFO entries; power of two, 2..16.
- `SYNC_STAGES`, 2, flops in the `spi_data_valid` synchronizer; at least 2.

Ports:
- `game_clk`  in  1  block clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `spi_data`  in  8  SPI byte, SPI clock domain; must stay stable while `spi_data_valid` is high.
  - [1:0] move command
  - [4:2] piece select
  - [5] move-valid
  - [7:6] ignored
- `spi_data_valid`  in  1  asynchronous level from `spi`; high while a byte is pending.
- `spi_clear`  out  1  level back to `spi`; requests that `spi_data_valid` be dropped.
- `cmd_valid`  out  1  the FIFO head is valid.
- `cmd_move`  out  2  head `spi_data[1:0]`.
- `cmd_piece`  out  3  head `spi_data[4:2]`; raw code, decoded downstream.
- `cmd_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `overflow`  out  1  sticky; set when a command is dropped because the FIFO is full.
- `drop_count`  out  8  number of dropped commands; saturates at 255.

## Operation
- **Synchronizer.** `spi_data_valid` passes through `SYNC_STAGES` flops to produce `valid_s`. `spi_data` is not synchronized; it is sampled only once `valid_s` is high.
- **Capture FSM: `IDLE`, `CAPTURE`, `CLEAR_WAIT`.**
  - `IDLE`: when `valid_s` is 1, register `spi_data` into `cap_q` and go to `CAPTURE`. Otherwise stay.
  - `CAPTURE`: act on `cap_q[5]`, then set `spi_clear` to 1 and go to `CLEAR_WAIT`.
    - `cap_q[5]` = 0: the byte is discarded. It is not counted as a drop.
    - `cap_q[5]` = 1 and a push is allowed: write {`cap_q[4:2]`, `cap_q[1:0]`} to the FIFO tail.
    - `cap_q[5]` = 1 and the FIFO is full with no pop this cycle: drop the byte, set `overflow`, and increment `drop_count` (saturating).
  - `CLEAR_WAIT`: hold `spi_clear` at 1 until `valid_s` is 0. Then set `spi_clear` to 0 and return to `IDLE`.
  - At most one capture happens per assertion of `spi_data_valid`.
- **FIFO.** `DEPTH` entries of 5 bits, held in a circular buffer with read and write pointers and a `count` register.
  - Show-ahead: `cmd_move` and `cmd_piece` always show the entry at the read pointer.
  - `cmd_valid` = (`count` != 0).
  - Pop = `cmd_valid` & `cmd_ready`. `cmd_ready` while the FIFO is empty has no effect.
  - A push is allowed when `count` < `DEPTH`, or when a pop happens in the same cycle.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - Pointers wrap modulo `DEPTH`.
- **Reset** (`reset_n` = 0 at a `game_clk` edge):
  - FSM goes to `IDLE`; synchronizer flops and `cap_q` are cleared; pointers and `count` are set to 0.
  - Outputs: `spi_clear` 0, `cmd_valid` 0, `cmd_move` 0, `cmd_piece` 0, `count` 0, `overflow` 0, `drop_count` 0.
  - Reset has priority over every other event.
  - Reset mid-capture abandons the byte. If `spi_data_valid` is still high after reset, the same byte is captured again. This is intended.
- **Data path.** All arithmetic is unsigned; `count` never exceeds `DEPTH`.

## Timing
- Edges are numbered from the first `game_clk` edge at which `spi_data_valid` = 1 is sampled (edge 1).
  - `valid_s` = 1 after edge `SYNC_STAGES`.
  - `cap_q` is loaded at edge `SYNC_STAGES`+1.
  - The push, and `spi_clear` rising, happen at edge `SYNC_STAGES`+2.
  - Default latency from `spi_data_valid` rising to `cmd_valid` = 1 (FIFO previously empty): 4 edges.
- `spi_clear` falls one edge after the first cycle in which `valid_s` = 0 is observed in `CLEAR_WAIT`.
- A pop takes effect at the edge where `cmd_valid` & `cmd_ready` = 1. The next entry, or `cmd_valid` = 0, is visible immediately after that edge. There is no bubble between back-to-back pops.
- `overflow` and `drop_count` update at the `CAPTURE` edge of the dropped byte.
- Minimum spacing between accepted bytes: `SYNC_STAGES`+2 edges plus the `spi_clear` round trip.

## Test plan
- **Reset.** Hold `reset_n` = 0 for 3 cycles with `spi_data_valid` = 0 → all outputs 0 and FSM in `IDLE`.
- **Single command.** Set `spi_data` = 8'h2D (valid, piece 3, move 1), raise `spi_data_valid` → at edge 4: `cmd_valid` = 1, `cmd_move` = 1, `cmd_piece` = 3, `spi_clear` = 1. Drop `valid` → `spi_clear` = 0 three edges later. With `cmd_ready` = 1 for one cycle → `count` = 0.
- **Ignored byte.** Send 8'h0E (bit5 = 0) → `count` stays 0, `overflow` stays 0, and `spi_clear` still pulses.
- **Overflow.** Hold `cmd_ready` = 0 and send 6 valid bytes 8'h20..8'h25 → `count` = 4, `overflow` = 1, `drop_count` = 2. Pops then return `cmd_move` 0,1,2,3 in order.
- **Simultaneous push and pop.** With `count` = 4 and `cmd_ready` = 1 during the `CAPTURE` edge → push accepted, `count` stays 4, `drop_count` unchanged, and read and write pointers wrap correctly.
- **Reset mid-capture.** Assert `reset_n` = 0 during `CAPTURE` while `spi_data_valid` stays high → all state cleared. After release, the same byte is captured once and `count` = 1.
